// File: rtl/dvp_frame_tx.sv
// DVP camera-port transmitter: turns an RGB565 pixel stream into
// vsync/href/8-bit data, two bytes per pixel with the high byte first.
// Owns frame and line timing and pulls pixels through a ready/valid handshake.
module dvp_frame_tx #(
  parameter int H_ACTIVE = 480,
  parameter int H_BLANK  = 64,
  parameter int V_ACTIVE = 272,
  parameter int VS_LINES = 2,
  parameter int V_BP     = 4,
  parameter int V_FP     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        frame_start,
  output logic        underflow
);

  localparam int LINE_LEN    = H_BLANK + 2 * H_ACTIVE;
  localparam int FRAME_LINES = VS_LINES + V_BP + V_ACTIVE + V_FP;
  localparam int HW          = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int VW          = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int V_ACT_FIRST = VS_LINES + V_BP;
  localparam int V_ACT_END   = VS_LINES + V_BP + V_ACTIVE;

  localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_BL   = HW'(H_BLANK);
  localparam logic [VW-1:0] V_LAST = VW'(FRAME_LINES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    lo_q, lo_d;
  logic          fs_q, fs_d;
  logic          uf_q, uf_d;

  logic          run;
  logic [31:0]   vcnt_w;
  logic          vs_line;
  logic          act_line;
  logic          in_act_h;
  logic          even_slot;
  logic          byte_slot;

  // Decode the current (state, hcnt, vcnt) position into timing regions.
  always_comb begin
    run       = (state_q == RUN);
    vcnt_w    = 32'(vcnt_q);
    vs_line   = (vcnt_w < 32'(VS_LINES));
    act_line  = (vcnt_w >= 32'(V_ACT_FIRST)) && (vcnt_w < 32'(V_ACT_END));
    in_act_h  = (hcnt_q >= H_BL);
    // (hcnt - H_BLANK) is even exactly when the LSBs agree
    even_slot = (hcnt_q[0] == H_BL[0]);
    byte_slot = run && act_line && in_act_h;
    pix_ready = byte_slot && even_slot;
  end

  // Frame FSM next state: IDLE waits for en, RUN walks the raster and only
  // re-checks en at the very last clock of a frame so frames never truncate.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          if (vcnt_q == V_LAST) begin
            vcnt_d = '0;
            if (!en) begin
              state_d = IDLE;
            end
          end else begin
            vcnt_d = vcnt_q + 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        hcnt_d  = '0;
        vcnt_d  = '0;
      end
    endcase
  end

  // Registered DVP outputs, one cycle behind the counter position.
  // The high byte goes out straight from the input; the low byte is parked
  // for the following clock. A missing pixel is sent as zeros so the byte
  // phase never slips.
  always_comb begin
    vsync_d = run && vs_line;
    href_d  = byte_slot;
    fs_d    = run && (hcnt_q == '0) && (vcnt_q == '0);
    lo_d    = lo_q;
    data_d  = 8'h00;
    uf_d    = uf_q;
    if (pix_ready) begin
      if (pix_valid) begin
        data_d = pix_data[15:8];
        lo_d   = pix_data[7:0];
      end else begin
        data_d = 8'h00;
        lo_d   = 8'h00;
        uf_d   = 1'b1;
      end
    end else if (byte_slot) begin
      data_d = lo_q;
    end
  end

  // FSM state and raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  // Output and pixel-byte registers; all clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      lo_q    <= 8'h00;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      lo_q    <= lo_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end

  assign dvp_vsync   = vsync_q;
  assign dvp_href    = href_q;
  assign dvp_data    = data_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

endmodule
